// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: stalls fetch on a miss, issues one block-aligned
// memory read, assembles the returning beats into a line and writes it in one cycle.
module icache_refill_ctrl #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512,
    parameter int BEAT_WIDTH  = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_fetch_valid,
    input  logic [ADDR_WIDTH-1:0]  i_fetch_addr,
    input  logic                   i_cache_hit,
    output logic                   o_stall,
    output logic                   o_cache_write_en,
    output logic [ADDR_WIDTH-1:0]  o_cache_addr,
    output logic [BLOCK_WIDTH-1:0] o_cache_block,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
    input  logic                   i_mem_rsp_valid,
    input  logic [BEAT_WIDTH-1:0]  i_mem_rsp_data,
    output logic [CNT_WIDTH-1:0]   o_miss_count
);

    localparam int BEATS       = BLOCK_WIDTH / BEAT_WIDTH;
    localparam int BEAT_CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET_BITS = $clog2(BLOCK_WIDTH / 8);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_FILL
    } state_e;

    state_e                                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]                  miss_addr_q, miss_addr_d;
    logic [BEATS-1:0][BEAT_WIDTH-1:0]       line_q, line_d;
    logic [BEAT_CNT_W-1:0]                  beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0]                   miss_count_q, miss_count_d;
    logic                                   miss;

    assign miss = i_fetch_valid & ~i_cache_hit;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q      <= S_IDLE;
            miss_addr_q  <= '0;
            line_q       <= '0;
            beat_cnt_q   <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            line_q       <= line_d;
            beat_cnt_q   <= beat_cnt_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        miss_addr_d      = miss_addr_q;
        line_d           = line_q;
        beat_cnt_d       = beat_cnt_q;
        miss_count_d     = miss_count_q;
        o_stall          = (state_q != S_IDLE);
        o_mem_req_valid  = 1'b0;
        o_cache_write_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The miss cycle itself must stall, so this path is combinational.
                if (miss) begin
                    o_stall     = 1'b1;
                    miss_addr_d = {i_fetch_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    if (miss_count_q != {CNT_WIDTH{1'b1}}) begin
                        miss_count_d = miss_count_q + CNT_WIDTH'(1);
                    end
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    beat_cnt_d = '0;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                // Beat n lands in line bits [n*BEAT_WIDTH +: BEAT_WIDTH].
                if (i_mem_rsp_valid) begin
                    line_d[beat_cnt_q] = i_mem_rsp_data;
                    beat_cnt_d         = beat_cnt_q + BEAT_CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                o_cache_write_en = 1'b1;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_mem_req_addr = miss_addr_q;
    assign o_cache_addr   = miss_addr_q;
    assign o_cache_block  = line_q;
    assign o_miss_count   = miss_count_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized scoreboard bench for icache_refill_ctrl: the driver derives per-cycle
// expectations from the refill timing rules; a negedge monitor pops and compares.
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fv = 1'b0;
    logic [63:0]  faddr = '0;
    logic         hit = 1'b0;
    logic         rdy = 1'b0;
    logic         rv = 1'b0;
    logic [63:0]  rdata = '0;

    logic         stall, we, reqv;
    logic [63:0]  caddr, raddr;
    logic [511:0] cblk;
    logic [31:0]  mcnt;

    logic         stall2, we2, reqv2;
    logic [63:0]  caddr2, raddr2;
    logic [511:0] cblk2;
    logic [1:0]   mcnt2;

    always #5 clk = ~clk;

    icache_refill_ctrl u_dut (
        .i_clk(clk), .i_arst(rst), .i_fetch_valid(fv), .i_fetch_addr(faddr),
        .i_cache_hit(hit), .o_stall(stall), .o_cache_write_en(we), .o_cache_addr(caddr),
        .o_cache_block(cblk), .o_mem_req_valid(reqv), .i_mem_req_ready(rdy),
        .o_mem_req_addr(raddr), .i_mem_rsp_valid(rv), .i_mem_rsp_data(rdata),
        .o_miss_count(mcnt)
    );

    icache_refill_ctrl #(.CNT_WIDTH(2)) u_dut_c2 (
        .i_clk(clk), .i_arst(rst), .i_fetch_valid(fv), .i_fetch_addr(faddr),
        .i_cache_hit(hit), .o_stall(stall2), .o_cache_write_en(we2), .o_cache_addr(caddr2),
        .o_cache_block(cblk2), .o_mem_req_valid(reqv2), .i_mem_req_ready(rdy),
        .o_mem_req_addr(raddr2), .i_mem_rsp_valid(rv), .i_mem_rsp_data(rdata),
        .o_miss_count(mcnt2)
    );

    typedef struct {
        bit chk;
        bit stall;
        bit reqv;
        bit we;
        bit rst_vals;
    } exp_t;

    typedef struct {
        logic [63:0]  addr;
        logic [511:0] blk;
        logic [31:0]  cnt;
        logic [1:0]   cnt2;
    } fill_t;

    exp_t        exp_q[$];
    logic [63:0] req_q[$];
    fill_t       fill_q[$];

    int checks = 0;
    int errors = 0;
    int n_miss = 0;

    function automatic exp_t mk(bit c, bit s, bit r, bit w, bit z);
        exp_t e;
        e.chk = c; e.stall = s; e.reqv = r; e.we = w; e.rst_vals = z;
        return e;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cmp(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, req);
        end
    endtask

    // One clock of stimulus plus the behaviour expected from the DUT in that cycle.
    task automatic drive(input logic f, input logic [63:0] a, input logic h, input logic r,
                         input logic v, input logic [63:0] d, input logic rs, input exp_t e);
        @(posedge clk);
        #1;
        fv = f; faddr = a; hit = h; rdy = r; rv = v; rdata = d; rst = rs;
        exp_q.push_back(e);
    endtask

    // Full miss: miss cycle, REQ (rdelay ready-low cycles), beats with gaps, FILL.
    // abort_after >= 0 asserts reset the cycle after that beat index.
    task automatic do_miss(input logic [63:0] addr, input int rdelay, input int gap [8],
                           input logic [63:0] beats [8], input bit stray, input int abort_after);
        logic [511:0] blk;
        fill_t        fr;
        blk = '0;
        n_miss++;
        req_q.push_back({addr[63:6], 6'b0});
        drive(1'b1, addr, 1'b0, 1'b0, stray, r64(), 1'b0, mk(1, 1, 0, 0, 0));
        for (int i = 0; i <= rdelay; i++)
            drive(rb(), r64(), rb(), (i == rdelay), stray & rb(), r64(), 1'b0, mk(1, 1, 1, 0, 0));
        for (int b = 0; b < 8; b++) begin
            blk[b*64 +: 64] = beats[b];
            drive(rb(), r64(), rb(), rb(), 1'b1, beats[b], 1'b0, mk(1, 1, 0, 0, 0));
            if (b == abort_after) begin
                drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, mk(1, 1, 0, 0, 0));
                n_miss = 0;
                for (int k = 0; k < 4; k++)
                    drive(1'b0, r64(), rb(), rb(), 1'b1, r64(), 1'b0, mk(1, 0, 0, 0, 1));
                return;
            end
            if (b < 7)
                for (int g = 0; g < gap[b]; g++)
                    drive(rb(), r64(), rb(), rb(), 1'b0, r64(), 1'b0, mk(1, 1, 0, 0, 0));
        end
        fr.addr = {addr[63:6], 6'b0};
        fr.blk  = blk;
        fr.cnt  = n_miss;
        fr.cnt2 = (n_miss > 3) ? 2'd3 : 2'(n_miss);
        fill_q.push_back(fr);
        drive(rb(), r64(), rb(), rb(), stray, r64(), 1'b0, mk(1, 1, 0, 1, 0));
    endtask

    task automatic hit_cycle(input logic [63:0] addr);
        drive(1'b1, addr, 1'b1, rb(), rb(), r64(), 1'b0, mk(1, 0, 0, 0, 0));
    endtask

    always @(negedge clk) begin
        exp_t  e;
        fill_t f;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                cmp("stall", stall, e.stall);
                cmp("mem_req_valid", reqv, e.reqv);
                cmp("cache_write_en", we, e.we);
                if (e.rst_vals) begin
                    cmp("rst_cache_addr", caddr, '0);
                    cmp("rst_req_addr", raddr, '0);
                    cmp("rst_block", cblk, '0);
                    cmp("rst_miss_count", mcnt, '0);
                    cmp("rst_miss_count_c2", mcnt2, '0);
                end
                if (reqv) begin
                    if (req_q.size() == 0) cmp("unexpected_req", 1'b1, 1'b0);
                    else begin
                        cmp("req_addr", raddr, req_q[0]);
                        if (rdy) void'(req_q.pop_front());
                    end
                end
                if (we) begin
                    if (fill_q.size() == 0) cmp("unexpected_fill", 1'b1, 1'b0);
                    else begin
                        f = fill_q.pop_front();
                        cmp("fill_addr", caddr, f.addr);
                        cmp("fill_block", cblk, f.blk);
                        cmp("miss_count", mcnt, f.cnt);
                        cmp("miss_count_c2", mcnt2, f.cnt2);
                    end
                end
            end
        end
    end

    initial begin
        int          gap [8];
        logic [63:0] beats [8];
        int          abort;

        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, mk(0, 0, 0, 0, 0));
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, mk(0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++)
            drive(1'b1, r64(), 1'b1, 1'b0, 1'b0, '0, 1'b0, mk(1, 0, 0, 0, 1));

        // Directed miss with immediate ready and back-to-back beats.
        for (int b = 0; b < 8; b++) begin
            gap[b]   = 0;
            beats[b] = {16{4'(b + 1)}};
        end
        do_miss(64'h8000_1234, 0, gap, beats, 1'b0, -1);
        hit_cycle(64'h8000_1234);

        // Ready held low 3 cycles, 2-cycle gaps after the 2nd and 5th beats, stray beats.
        gap[1] = 2;
        gap[4] = 2;
        for (int b = 0; b < 8; b++) beats[b] = r64();
        do_miss(64'h0000_0040_0000_07FF, 3, gap, beats, 1'b1, -1);
        hit_cycle(64'h0000_0040_0000_07FF);

        // Reset after the 4th beat, then a clean refill.
        for (int b = 0; b < 8; b++) begin gap[b] = 0; beats[b] = r64(); end
        do_miss(r64(), 1, gap, beats, 1'b0, 3);
        for (int m = 0; m < 5; m++) begin
            for (int b = 0; b < 8; b++) beats[b] = r64();
            do_miss(r64(), 0, gap, beats, 1'b0, -1);
            hit_cycle(r64());
        end

        for (int m = 0; m < 40; m++) begin
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                if (rb()) hit_cycle(r64());
                else drive(1'b0, r64(), rb(), rb(), rb(), r64(), 1'b0, mk(1, 0, 0, 0, 0));
            end
            for (int b = 0; b < 8; b++) begin
                gap[b]   = $urandom_range(0, 2);
                beats[b] = r64();
            end
            abort = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
            do_miss(r64(), $urandom_range(0, 3), gap, beats, rb(), abort);
            hit_cycle(r64());
        end

        for (int i = 0; i < 4; i++)
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, mk(1, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        cmp("pending_expect", 32'(exp_q.size()), 32'd0);
        cmp("pending_req", 32'(req_q.size()), 32'd0);
        cmp("pending_fill", 32'(fill_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-handling and refill controller for the direct-mapped instruction cache. Sits between the fetch stage, the instruction cache and the memory read port. On a fetch miss it stalls fetch, issues one block-aligned read request, collects the returning beats into a full cache line, and writes that line into the cache in a single cycle.

## Interface

Parameters:
- ADDR_WIDTH, 64, fetch/memory address width
- BLOCK_WIDTH, 512, cache line width in bits
- BEAT_WIDTH, 64, memory response beat width; BEATS = BLOCK_WIDTH/BEAT_WIDTH (8)
- CNT_WIDTH, 32, miss counter width

Ports:
- i_clk  in  1  clock
- i_arst  in  1  reset; synchronous, active-high
- i_fetch_valid  in  1  fetch stage presents a valid address
- i_fetch_addr  in  ADDR_WIDTH  fetch address
- i_cache_hit  in  1  hit from instruction cache for i_fetch_addr
- o_stall  out  1  fetch must hold its address
- o_cache_write_en  out  1  line write strobe to cache
- o_cache_addr  out  ADDR_WIDTH  address for line write (block-aligned)
- o_cache_block  out  BLOCK_WIDTH  line data to cache
- o_mem_req_valid  out  1  read request valid
- i_mem_req_ready  in  1  memory accepts request
- o_mem_req_addr  out  ADDR_WIDTH  block-aligned request address
- i_mem_rsp_valid  in  1  response beat valid (no backpressure)
- i_mem_rsp_data  in  BEAT_WIDTH  response beat
- o_miss_count  out  CNT_WIDTH  saturating count of misses serviced

## Operation

- States: IDLE, REQ, RESP, FILL. Reset → IDLE.
- IDLE: if i_fetch_valid & !i_cache_hit → latch i_fetch_addr with low log2(BLOCK_WIDTH/8) bits cleared into miss_addr, increment o_miss_count (saturates at all-ones), go REQ. Otherwise stay.
- REQ: o_mem_req_valid=1, o_mem_req_addr=miss_addr. On i_mem_req_ready → RESP, beat counter=0. Request held stable until accepted.
- RESP: each i_mem_rsp_valid writes i_mem_rsp_data into line buffer bits [(cnt+1)*BEAT_WIDTH-1 -: BEAT_WIDTH], cnt++. Beat with cnt==BEATS-1 → FILL. Gaps between beats allowed.
- FILL: o_cache_write_en=1 for exactly one cycle, o_cache_addr=miss_addr, o_cache_block=line buffer → IDLE.
- o_stall = (state==IDLE & i_fetch_valid & !i_cache_hit) | (state!=IDLE). Combinational in IDLE, so the miss cycle itself is stalled.
- i_fetch_addr, i_cache_hit ignored outside IDLE; refill always completes for miss_addr.
- i_mem_rsp_valid outside RESP: beat dropped, no state change.
- o_cache_addr/o_mem_req_addr drive miss_addr in all states; o_cache_block drives buffer in all states.
- One outstanding request maximum; no new miss accepted until back in IDLE.

## Timing

- Reset values: o_stall=0 (when i_fetch_valid=0), o_cache_write_en=0, o_mem_req_valid=0, o_cache_addr=0, o_mem_req_addr=0, o_cache_block=0, o_miss_count=0, beat counter=0.
- Reset asserted in any state → IDLE next edge, buffer, counter, miss_addr cleared; in-flight beats afterwards are dropped.
- Miss penalty with ready same cycle as REQ and back-to-back beats: miss seen cycle 0; REQ cycle 1; beats cycles 2..9; FILL cycle 10; IDLE cycle 11 with cache hit → o_stall low. o_stall high cycles 0..10 (BEATS+3).
- Each cycle of ready-low in REQ or rsp gap in RESP adds one stall cycle.
- Write occurs at end of FILL cycle; cache reports hit from next cycle.

## Test plan

- Reset then i_fetch_valid=1, i_cache_hit=1 for 20 cycles → o_stall=0, o_mem_req_valid=0, o_cache_write_en=0, o_miss_count=0.
- Miss at addr 0x8000_1234, ready immediate, beats 0x1111..1 through 0x8888..8 back-to-back → o_mem_req_addr=0x8000_1200 in cycle 1, o_cache_write_en pulse cycle 10 with block[63:0]=0x1111..1, block[511:448]=0x8888..8, o_miss_count=1, o_stall falls cycle 11.
- Miss with i_mem_req_ready low 3 cycles and 2-cycle gaps after beats 2 and 5 → request addr stable while waiting, write pulse at cycle 10+3+4=17, data order correct.
- i_mem_rsp_valid pulses in IDLE and REQ → ignored; later refill line contains only RESP-state beats.
- Reset asserted after beat 4 → next cycle IDLE, all outputs at reset values, subsequent leftover beats ignored, next miss refills cleanly.
- CNT_WIDTH=2, five misses → o_miss_count 1,2,3,3,3.
